// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage hazard controller.
//   state_e   : controller state (RUN / MEMWAIT / DIV / DEFER).
//   STG_*     : bit index of each pipeline register inside bubble/write vectors.
package hazard_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StDiv     = 2'd2,
      StDefer   = 2'd3
   } state_e;

   localparam logic [1:0] STG_IFID  = 2'd0;
   localparam logic [1:0] STG_IDEX  = 2'd1;
   localparam logic [1:0] STG_EXMEM = 2'd2;
   localparam logic [1:0] STG_MEMWB = 2'd3;

endpackage

// File: rtl/hazard_ctrl_fsm_if.sv
// hazard_ctrl_fsm_if: bundle of hazard inputs and pipeline-control outputs.
//   slave  : controller side (hazard/event inputs in, stall/bubble controls out).
//   master : pipeline side (drives hazard/event inputs, receives controls).
interface hazard_ctrl_fsm_if #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 8
);

   logic [REG_W-1:0] ifid_rs1;
   logic [REG_W-1:0] ifid_rs2;
   logic [REG_W-1:0] idex_rd;
   logic             idex_memread;
   logic             idex_memwrite;
   logic             ifid_memread;
   logic             mem_ready;
   logic             jump;
   logic             trap_in_id;
   logic             syscall;
   logic             int_trap;
   logic             flush;
   logic             pcsrc;
   logic             idex_branch;
   logic             exmem_branch;
   logic             div_start;
   logic [3:0]       bubble;
   logic [3:0]       write;
   logic             write_pc;
   logic             instr_en;
   logic             trap_waiting;
   logic             div_busy;
   logic [CNT_W-1:0] mem_wait_cycles;

   modport slave (
      input  ifid_rs1, ifid_rs2, idex_rd, idex_memread, idex_memwrite, ifid_memread,
             mem_ready, jump, trap_in_id, syscall, int_trap, flush, pcsrc,
             idex_branch, exmem_branch, div_start,
      output bubble, write, write_pc, instr_en, trap_waiting, div_busy, mem_wait_cycles
   );

   modport master (
      output ifid_rs1, ifid_rs2, idex_rd, idex_memread, idex_memwrite, ifid_memread,
             mem_ready, jump, trap_in_id, syscall, int_trap, flush, pcsrc,
             idex_branch, exmem_branch, div_start,
      input  bubble, write, write_pc, instr_en, trap_waiting, div_busy, mem_wait_cycles
   );

endinterface

// File: rtl/hazard_detect_cmp.sv
// hazard_detect_cmp: combinational load-use and structural hazard comparator.
//   rs1, rs2       : source registers of the instruction in ID.
//   rd             : destination register of the instruction in EX.
//   idex_memread   : EX instruction is a load.
//   idex_memwrite  : EX instruction is a store.
//   ifid_memread   : ID instruction is a load.
//   load_use       : ID reads a register the EX load has not produced yet.
//   structural     : load in ID behind a store in EX.
//   stall          : either hazard.
module hazard_detect_cmp #(
   parameter int unsigned REG_W     = 5,
   parameter bit          ZERO_SKIP = 1'b1
) (
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [REG_W-1:0] rd,
   input  logic             idex_memread,
   input  logic             idex_memwrite,
   input  logic             ifid_memread,
   output logic             load_use,
   output logic             structural,
   output logic             stall
);

   logic rd_masked;

   // x0 is hardwired, so a load into it never produces a value worth waiting for.
   assign rd_masked  = ZERO_SKIP && (rd == '0);
   assign load_use   = idex_memread && ((rd == rs1) || (rd == rs2)) && !rd_masked;
   assign structural = ifid_memread && idex_memwrite;
   assign stall      = load_use || structural;

endmodule

// File: rtl/hazard_ctrl_fsm.sv
// hazard_ctrl_fsm: registered ID-stage stall/bubble controller.
//   clock : rising-edge clock.
//   reset : asynchronous active-low reset.
//   hz    : hazard inputs and pipeline controls (bubble/write per pipeline register,
//           write_pc, instr_en, trap_waiting, div_busy, mem_wait_cycles).
// Tracks memory waits (with a saturating length counter), multi-cycle divides and
// syscalls deferred behind unresolved branches; all outputs are combinational.
module hazard_ctrl_fsm #(
   parameter int unsigned REG_W      = 5,
   parameter int unsigned DIV_CYCLES = 32,
   parameter bit          ZERO_SKIP  = 1'b1,
   parameter int unsigned CNT_W      = 8
) (
   input logic             clock,
   input logic             reset,
   hazard_ctrl_fsm_if.slave hz
);

   import hazard_pkg::*;

   localparam int unsigned DIV_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

   logic       load_use, structural, id_stall, branch_pend;
   logic [3:0] bubble, write;
   logic       write_pc, instr_en, trap_waiting, div_busy;

   hazard_detect_cmp #(
      .REG_W     (REG_W),
      .ZERO_SKIP (ZERO_SKIP)
   ) u_cmp (
      .rs1           (hz.ifid_rs1),
      .rs2           (hz.ifid_rs2),
      .rd            (hz.idex_rd),
      .idex_memread  (hz.idex_memread),
      .idex_memwrite (hz.idex_memwrite),
      .ifid_memread  (hz.ifid_memread),
      .load_use      (load_use),
      .structural    (structural),
      .stall         (id_stall)
   );

   assign branch_pend = hz.idex_branch || hz.exmem_branch;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StRun;
         mem_cnt_q <= '0;
         div_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mem_cnt_q <= mem_cnt_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_cnt_d    = mem_cnt_q;
      div_cnt_d    = div_cnt_q;
      bubble       = '0;
      write        = '1;
      write_pc     = 1'b1;
      instr_en     = 1'b1;
      trap_waiting = hz.syscall;
      div_busy     = 1'b0;

      unique case (state_q)
         StRun: begin
            if (!hz.mem_ready) begin
               // Fetch stays enabled so the pending access can complete.
               write        = '0;
               write_pc     = 1'b0;
               trap_waiting = 1'b0;
               mem_cnt_d    = CNT_W'(1);
               state_d      = StMemWait;
            end else if (hz.div_start) begin
               write     = '0;
               write_pc  = 1'b0;
               instr_en  = 1'b0;
               div_busy  = 1'b1;
               // This cycle is the first of the stall, DIV covers the rest.
               div_cnt_d = DIV_W'(DIV_CYCLES - 2);
               state_d   = StDiv;
            end else if (hz.syscall && branch_pend) begin
               bubble[STG_IDEX] = 1'b1;
               write[STG_IFID]  = 1'b0;
               trap_waiting     = 1'b0;
               state_d          = StDefer;
            end else if (id_stall) begin
               bubble[STG_IDEX] = 1'b1;
               write[STG_IFID]  = 1'b0;
               write_pc         = 1'b0;
               instr_en         = 1'b0;
               trap_waiting     = 1'b0;
            end else if (hz.jump || hz.trap_in_id) begin
               bubble[STG_IFID] = 1'b1;
            end
         end
         StMemWait: begin
            if (!hz.mem_ready) begin
               write        = '0;
               write_pc     = 1'b0;
               trap_waiting = 1'b0;
               if (mem_cnt_q != '1) begin
                  mem_cnt_d = mem_cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = StRun;
            end
         end
         StDiv: begin
            write        = '0;
            write_pc     = 1'b0;
            instr_en     = 1'b0;
            trap_waiting = 1'b0;
            div_busy     = 1'b1;
            if (div_cnt_q == '0) begin
               state_d = StRun;
            end else begin
               div_cnt_d = div_cnt_q - DIV_W'(1);
            end
         end
         StDefer: begin
            if (!hz.syscall) begin
               state_d = StRun;
            end else if (branch_pend) begin
               bubble[STG_IDEX] = 1'b1;
               write[STG_IFID]  = 1'b0;
               trap_waiting     = 1'b0;
            end else begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase

      // Asynchronous interrupt squashes the whole pipe and aborts any stall.
      if (hz.int_trap) begin
         bubble       = '1;
         write        = '1;
         write_pc     = 1'b1;
         instr_en     = 1'b1;
         trap_waiting = hz.syscall;
         div_busy     = 1'b0;
         state_d      = StRun;
      end else if (hz.pcsrc) begin
         bubble[STG_EXMEM:STG_IFID] = 3'b111;
         write_pc                   = 1'b1;
         instr_en                   = 1'b0;
         if (state_q == StDefer) begin
            state_d = StRun;
         end
      end
      if (hz.flush) begin
         bubble[STG_IFID] = 1'b1;
      end

      if (!reset) begin
         bubble       = '1;
         write        = '0;
         write_pc     = 1'b0;
         instr_en     = 1'b0;
         trap_waiting = 1'b0;
         div_busy     = 1'b0;
      end
   end

   assign hz.bubble          = bubble;
   assign hz.write           = write;
   assign hz.write_pc        = write_pc;
   assign hz.instr_en        = instr_en;
   assign hz.trap_waiting    = trap_waiting;
   assign hz.div_busy        = div_busy;
   assign hz.mem_wait_cycles = mem_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// tb_hazard_ctrl_fsm: directed scenarios plus randomized run against a
// behavioural model of the hazard controller.
module tb_hazard_ctrl_fsm;

   localparam int unsigned DIVC = 4;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   hazard_ctrl_fsm_if #(.REG_W(5), .CNT_W(8)) bus ();

   hazard_ctrl_fsm #(
      .REG_W      (5),
      .DIV_CYCLES (DIVC),
      .ZERO_SKIP  (1'b1),
      .CNT_W      (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .hz    (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // {bubble, write, write_pc, instr_en, trap_waiting, div_busy}
   function automatic logic [11:0] obs();
      return {bus.bubble, bus.write, bus.write_pc, bus.instr_en, bus.trap_waiting, bus.div_busy};
   endfunction

   function automatic logic [11:0] pk(logic [3:0] b, logic [3:0] w, logic wpc, logic ie,
                                      logic tw, logic db);
      return {b, w, wpc, ie, tw, db};
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.ifid_rs1      = 5'd1;
      bus.ifid_rs2      = 5'd2;
      bus.idex_rd       = 5'd3;
      bus.idex_memread  = 1'b0;
      bus.idex_memwrite = 1'b0;
      bus.ifid_memread  = 1'b0;
      bus.mem_ready     = 1'b1;
      bus.jump          = 1'b0;
      bus.trap_in_id    = 1'b0;
      bus.syscall       = 1'b0;
      bus.int_trap      = 1'b0;
      bus.flush         = 1'b0;
      bus.pcsrc         = 1'b0;
      bus.idex_branch   = 1'b0;
      bus.exmem_branch  = 1'b0;
      bus.div_start     = 1'b0;
   endtask

   task automatic test_reset();
      logic [11:0] e;
      idle();
      reset = 1'b0;
      #3;
      e = pk(4'hF, 4'h0, 0, 0, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=%h", obs(), e);
      end
      total++;
      if (bus.mem_wait_cycles !== 8'd0) begin
         bad++;
         $display("FAIL reset_count got=%0d want=0", bus.mem_wait_cycles);
      end
      cyc();
      reset = 1'b1;
      #1;
      e = pk(4'h0, 4'hF, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL reset_release got=%h want=%h", obs(), e);
      end
   endtask

   task automatic test_load_use();
      logic [11:0] e;
      cyc();
      bus.idex_memread = 1'b1;
      bus.idex_rd      = 5'd7;
      bus.ifid_rs2     = 5'd7;
      #1;
      e = pk(4'b0010, 4'b1110, 0, 0, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL load_use got=%h want=%h", obs(), e);
      end
      cyc();
      idle();
      #1;
      e = pk(4'h0, 4'hF, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL load_use_clear got=%h want=%h", obs(), e);
      end
      cyc();
      bus.idex_memread = 1'b1;
      bus.idex_rd      = 5'd0;
      bus.ifid_rs1     = 5'd0;
      #1;
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL load_use_x0 got=%h want=%h", obs(), e);
      end
      cyc();
      idle();
      bus.ifid_memread  = 1'b1;
      bus.idex_memwrite = 1'b1;
      #1;
      e = pk(4'b0010, 4'b1110, 0, 0, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL structural got=%h want=%h", obs(), e);
      end
      cyc();
      idle();
   endtask

   task automatic test_divide();
      logic [11:0] e;
      cyc();
      bus.div_start = 1'b1;
      for (int i = 0; i < int'(DIVC); i++) begin
         #1;
         e = pk(4'h0, 4'h0, 0, 0, 0, 1);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL div_busy_c%0d got=%h want=%h", i, obs(), e);
         end
         cyc();
         bus.div_start = 1'b0;
      end
      #1;
      e = pk(4'h0, 4'hF, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL div_end got=%h want=%h", obs(), e);
      end
      // Abort with an interrupt in the third stall cycle.
      cyc();
      bus.div_start = 1'b1;
      cyc();
      bus.div_start = 1'b0;
      cyc();
      bus.int_trap = 1'b1;
      #1;
      e = pk(4'hF, 4'hF, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL div_int_trap got=%h want=%h", obs(), e);
      end
      cyc();
      bus.int_trap = 1'b0;
      #1;
      e = pk(4'h0, 4'hF, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL div_after_trap got=%h want=%h", obs(), e);
      end
   endtask

   task automatic test_mem_wait();
      logic [11:0] e;
      int          nbad;
      cyc();
      bus.mem_ready = 1'b0;
      nbad = 0;
      e = pk(4'h0, 4'h0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL mem_wait_c%0d got=%h want=%h", i, obs(), e);
         end
         cyc();
      end
      bus.mem_ready = 1'b1;
      #1;
      e = pk(4'h0, 4'hF, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL mem_release got=%h want=%h", obs(), e);
      end
      total++;
      if (bus.mem_wait_cycles !== 8'd5) begin
         bad++;
         $display("FAIL mem_count5 got=%0d want=5", bus.mem_wait_cycles);
      end
      cyc();
      bus.mem_ready = 1'b0;
      repeat (300) cyc();
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if (bus.mem_wait_cycles !== 8'd255) begin
         bad++;
         $display("FAIL mem_count_sat got=%0d want=255", bus.mem_wait_cycles);
      end
      cyc();
   endtask

   task automatic test_defer();
      logic [11:0] e;
      cyc();
      bus.syscall      = 1'b1;
      bus.exmem_branch = 1'b1;
      e = pk(4'b0010, 4'b1110, 1, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL defer_hold_c%0d got=%h want=%h", i, obs(), e);
         end
         cyc();
      end
      bus.exmem_branch = 1'b0;
      #1;
      e = pk(4'h0, 4'hF, 1, 1, 1, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL defer_release got=%h want=%h", obs(), e);
      end
      cyc();
      idle();
      cyc();
      // pcsrc squashes the deferred syscall.
      bus.syscall     = 1'b1;
      bus.idex_branch = 1'b1;
      cyc();
      bus.pcsrc = 1'b1;
      #1;
      e = pk(4'b0111, 4'b1110, 1, 0, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL defer_pcsrc got=%h want=%h", obs(), e);
      end
      cyc();
      idle();
      bus.mem_ready = 1'b0;
      #1;
      // Only RUN reacts to mem_ready, so this shows the state left DEFER.
      e = pk(4'h0, 4'h0, 0, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL defer_back_run got=%h want=%h", obs(), e);
      end
      cyc();
      idle();
      cyc();
   endtask

   task automatic test_reset_mid_div();
      logic [11:0] e;
      bus.div_start = 1'b1;
      cyc();
      bus.div_start = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      e = pk(4'hF, 4'h0, 0, 0, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL reset_in_div got=%h want=%h", obs(), e);
      end
      total++;
      if (bus.mem_wait_cycles !== 8'd0) begin
         bad++;
         $display("FAIL reset_in_div_count got=%0d want=0", bus.mem_wait_cycles);
      end
      cyc();
      reset = 1'b1;
      #1;
      e = pk(4'h0, 4'hF, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin
         bad++;
         $display("FAIL reset_div_release got=%h want=%h", obs(), e);
      end
   endtask

   task automatic test_random();
      // Model: stall cycles still owed to a divide, whether a memory wait is
      // in progress and its length so far, whether a syscall is being held.
      int          div_left, n_div_left;
      bit          waiting, n_waiting;
      int          wait_len, n_wait_len;
      bit          deferring, n_deferring;
      logic [3:0]  b, w;
      logic        wpc, ie, tw, db;
      bit          pend, lu, st;
      logic [11:0] e;
      reset = 1'b0;
      idle();
      cyc();
      reset = 1'b1;
      div_left  = 0;
      waiting   = 1'b0;
      wait_len  = 0;
      deferring = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         bus.ifid_rs1      = 5'($urandom_range(0, 7));
         bus.ifid_rs2      = 5'($urandom_range(0, 7));
         bus.idex_rd       = 5'($urandom_range(0, 7));
         bus.idex_memread  = ($urandom_range(0, 2) == 0);
         bus.idex_memwrite = ($urandom_range(0, 3) == 0);
         bus.ifid_memread  = ($urandom_range(0, 3) == 0);
         bus.mem_ready     = ($urandom_range(0, 7) != 0);
         bus.jump          = ($urandom_range(0, 7) == 0);
         bus.trap_in_id    = ($urandom_range(0, 19) == 0);
         bus.syscall       = ($urandom_range(0, 2) == 0);
         bus.int_trap      = ($urandom_range(0, 39) == 0);
         bus.flush         = ($urandom_range(0, 9) == 0);
         bus.pcsrc         = ($urandom_range(0, 14) == 0);
         bus.idex_branch   = ($urandom_range(0, 2) == 0);
         bus.exmem_branch  = ($urandom_range(0, 2) == 0);
         bus.div_start     = ($urandom_range(0, 11) == 0);
         #1;
         pend = bus.idex_branch || bus.exmem_branch;
         lu   = bus.idex_memread && (bus.idex_rd != 0) &&
                (bus.idex_rd == bus.ifid_rs1 || bus.idex_rd == bus.ifid_rs2);
         st   = bus.ifid_memread && bus.idex_memwrite;
         b = 4'h0; w = 4'hF; wpc = 1; ie = 1; tw = bus.syscall; db = 0;
         n_div_left = div_left; n_waiting = waiting; n_wait_len = wait_len;
         n_deferring = deferring;
         if (div_left > 0) begin
            w = 0; wpc = 0; ie = 0; tw = 0; db = 1;
            n_div_left = div_left - 1;
         end else if (waiting) begin
            if (!bus.mem_ready) begin
               w = 0; wpc = 0; tw = 0;
               n_wait_len = (wait_len < 255) ? wait_len + 1 : 255;
            end else begin
               n_waiting = 0;
            end
         end else if (deferring) begin
            if (bus.syscall && pend) begin
               b[1] = 1; w[0] = 0; tw = 0;
            end else begin
               n_deferring = 0;
            end
         end else if (!bus.mem_ready) begin
            w = 0; wpc = 0; tw = 0;
            n_waiting = 1; n_wait_len = 1;
         end else if (bus.div_start) begin
            w = 0; wpc = 0; ie = 0; db = 1;
            n_div_left = int'(DIVC) - 1;
         end else if (bus.syscall && pend) begin
            b[1] = 1; w[0] = 0; tw = 0;
            n_deferring = 1;
         end else if (lu || st) begin
            b[1] = 1; w[0] = 0; wpc = 0; ie = 0; tw = 0;
         end else if (bus.jump || bus.trap_in_id) begin
            b[0] = 1;
         end
         if (bus.int_trap) begin
            b = 4'hF; w = 4'hF; wpc = 1; ie = 1; tw = bus.syscall; db = 0;
            n_div_left = 0; n_waiting = 0; n_deferring = 0;
         end else if (bus.pcsrc) begin
            b = b | 4'b0111; wpc = 1; ie = 0;
            if (deferring) n_deferring = 0;
         end
         if (bus.flush) b[0] = 1;
         e = pk(b, w, wpc, ie, tw, db);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL rand_ctrl n=%0d got=%h want=%h", n, obs(), e);
         end
         total++;
         if (bus.mem_wait_cycles !== 8'(wait_len)) begin
            bad++;
            $display("FAIL rand_count n=%0d got=%0d want=%0d", n, bus.mem_wait_cycles,
                     wait_len);
         end
         cyc();
         div_left  = n_div_left;
         waiting   = n_waiting;
         wait_len  = n_wait_len;
         deferring = n_deferring;
      end
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_load_use();
      test_divide();
      test_mem_wait();
      test_defer();
      test_reset_mid_div();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
